// File: rtl/ps2_pkg.sv
// Shared constants, packet FSM states and the delta saturation helper for
// the PS/2 mouse receiver.
package ps2_pkg;

  // Error codes reported on o_err_code
  localparam logic [1:0] ERR_FRAME   = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_SYNC    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // One PS/2 word: start, 8 data bits, parity, stop
  localparam int FRAME_BITS = 11;

  // Header byte bit positions
  localparam int BTN_L   = 0;
  localparam int BTN_R   = 1;
  localparam int BTN_M   = 2;
  localparam int ALWAYS1 = 3;
  localparam int XS      = 4;
  localparam int YS      = 5;
  localparam int XO      = 6;
  localparam int YO      = 7;

  // Packet assembly states
  typedef enum logic [1:0] {
    ST_HDR = 2'd0,
    ST_BX  = 2'd1,
    ST_BY  = 2'd2,
    ST_BZ  = 2'd3
  } pkt_state_t;

  // 9-bit two's complement delta; an overflowed axis pins to the extreme
  // value in the direction given by its sign bit.
  function automatic logic [8:0] sat_delta(input logic sign, input logic ovf,
                                           input logic [7:0] data);
    if (ovf)
      sat_delta = sign ? 9'h100 : 9'h0FF;
    else
      sat_delta = {sign, data};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 word receiver: synchronises the raw lines, samples data on falling
// clock edges, checks start/parity/stop and watches for stalled transfers.
// byte_valid and err are combinational strobes in the cycle of the stop-bit
// sample (or timeout expiry) so the packet logic can register them directly.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int P_TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       pkt_busy,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int TW = $clog2(P_TIMEOUT_CYC + 1);

  logic                  clk_meta_reg, sync_clk_reg, sync_clk_d_reg;
  logic                  data_meta_reg, sync_data_reg;
  logic [3:0]            bit_cnt_reg;
  logic [FRAME_BITS-2:0] shift_reg;
  logic [TW-1:0]         to_cnt_reg;

  logic                  fall, last_bit, to_run, to_expire;
  logic                  frame_ok, parity_ok;
  logic [FRAME_BITS-1:0] frame;

  // Two-flop synchronisers plus one delay stage for edge detection; idle high
  always_ff @(posedge clk) begin
    if (srst) begin
      clk_meta_reg   <= 1'b1;
      sync_clk_reg   <= 1'b1;
      sync_clk_d_reg <= 1'b1;
      data_meta_reg  <= 1'b1;
      sync_data_reg  <= 1'b1;
    end else begin
      clk_meta_reg   <= ps2_clk;
      sync_clk_reg   <= clk_meta_reg;
      sync_clk_d_reg <= sync_clk_reg;
      data_meta_reg  <= ps2_data;
      sync_data_reg  <= data_meta_reg;
    end
  end

  assign fall      = sync_clk_d_reg & ~sync_clk_reg;
  assign last_bit  = fall && (bit_cnt_reg == 4'(FRAME_BITS - 1));
  // frame[0] start, frame[8:1] data, frame[9] parity, frame[10] stop
  assign frame     = {sync_data_reg, shift_reg};
  assign frame_ok  = ~frame[0] & frame[FRAME_BITS-1];
  assign parity_ok = ^frame[9:1];
  assign to_run    = (bit_cnt_reg != 4'd0) || pkt_busy;
  // A falling edge in the expiry cycle keeps the transfer alive
  assign to_expire = to_run && !fall && (to_cnt_reg == TW'(P_TIMEOUT_CYC - 1));

  // Bit counter and LSB-first shift register, advanced on each falling edge
  always_ff @(posedge clk) begin
    if (srst) begin
      bit_cnt_reg <= 4'd0;
      shift_reg   <= '0;
    end else if (fall) begin
      bit_cnt_reg <= last_bit ? 4'd0 : bit_cnt_reg + 4'd1;
      shift_reg   <= {sync_data_reg, shift_reg[FRAME_BITS-2:1]};
    end else if (to_expire) begin
      bit_cnt_reg <= 4'd0;
    end
  end

  // Inactivity counter: restarts on every edge, idles at zero when nothing is pending
  always_ff @(posedge clk) begin
    if (srst || fall || to_expire || !to_run)
      to_cnt_reg <= '0;
    else
      to_cnt_reg <= to_cnt_reg + 1'b1;
  end

  assign rx_byte    = frame[8:1];
  assign byte_valid = last_bit & frame_ok & parity_ok;
  assign err        = (last_bit & ~(frame_ok & parity_ok)) | to_expire;
  assign err_code   = to_expire ? ERR_TIMEOUT : (!frame_ok ? ERR_FRAME : ERR_PARITY);

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse front end: assembles 3- or 4-byte packets from received
// words, saturates overflowed deltas and keeps a clamped cursor position.
module ps2_mouse_rx
  import ps2_pkg::*;
#(
  parameter int P_CLK_HZ     = 100_000_000,
  parameter int P_TIMEOUT_US = 2000,
  parameter int P_WHEEL      = 0,
  parameter int P_POS_W      = 12,
  parameter int P_X_MAX      = 639,
  parameter int P_Y_MAX      = 479
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_PS2Clk,
  input  logic               i_PS2Data,
  output logic [8:0]         o_dx,
  output logic [8:0]         o_dy,
  output logic [3:0]         o_wheel,
  output logic [2:0]         o_btn,
  output logic [P_POS_W-1:0] o_x,
  output logic [P_POS_W-1:0] o_y,
  output logic               o_valid,
  output logic               o_err,
  output logic [1:0]         o_err_code
);

  localparam int         TIMEOUT_CYC = P_CLK_HZ / 1_000_000 * P_TIMEOUT_US;
  localparam int         SW          = P_POS_W + 2;
  localparam pkt_state_t ST_LAST     = (P_WHEEL != 0) ? ST_BZ : ST_BY;

  pkt_state_t state_reg;
  logic [2:0] btn_reg;
  logic       xs_reg, ys_reg, xo_reg, yo_reg;
  logic [7:0] x_reg, y_reg;

  logic [7:0]          rx_byte, y_byte;
  logic                byte_valid, frame_err, last_byte;
  logic [1:0]          frame_err_code;
  logic [8:0]          dx_next, dy_next;
  logic signed [SW-1:0] x_sum, y_sum;
  logic [P_POS_W-1:0]  x_next, y_next;

  ps2_frame_rx #(
    .P_TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame (
    .clk       (i_clk),
    .srst      (i_reset),
    .ps2_clk   (i_PS2Clk),
    .ps2_data  (i_PS2Data),
    .pkt_busy  (state_reg != ST_HDR),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .err       (frame_err),
    .err_code  (frame_err_code)
  );

  // In 3-byte mode the Y byte is the one arriving now; with a wheel it was stored earlier
  assign y_byte    = (state_reg == ST_BY) ? rx_byte : y_reg;
  assign last_byte = byte_valid && (state_reg == ST_LAST);
  assign dx_next   = sat_delta(xs_reg, xo_reg, x_reg);
  assign dy_next   = sat_delta(ys_reg, yo_reg, y_byte);
  // Screen Y grows downward while PS/2 Y grows upward, hence the subtraction
  assign x_sum     = $signed({2'b00, o_x}) + SW'($signed(dx_next));
  assign y_sum     = $signed({2'b00, o_y}) - SW'($signed(dy_next));

  // Clamp the widened sums into the visible area
  always_comb begin
    x_next = x_sum[P_POS_W-1:0];
    y_next = y_sum[P_POS_W-1:0];
    if (x_sum[SW-1])
      x_next = '0;
    else if (x_sum > SW'(P_X_MAX))
      x_next = P_POS_W'(P_X_MAX);
    if (y_sum[SW-1])
      y_next = '0;
    else if (y_sum > SW'(P_Y_MAX))
      y_next = P_POS_W'(P_Y_MAX);
  end

  // Packet FSM, error reporting and registered packet outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg  <= ST_HDR;
      btn_reg    <= 3'd0;
      xs_reg     <= 1'b0;
      ys_reg     <= 1'b0;
      xo_reg     <= 1'b0;
      yo_reg     <= 1'b0;
      x_reg      <= 8'd0;
      y_reg      <= 8'd0;
      o_dx       <= 9'd0;
      o_dy       <= 9'd0;
      o_wheel    <= 4'd0;
      o_btn      <= 3'd0;
      o_x        <= P_POS_W'(P_X_MAX / 2);
      o_y        <= P_POS_W'(P_Y_MAX / 2);
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= 2'b00;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (frame_err) begin
        o_err      <= 1'b1;
        o_err_code <= frame_err_code;
        state_reg  <= ST_HDR;
      end else if (byte_valid) begin
        case (state_reg)
          ST_HDR: begin
            if (rx_byte[ALWAYS1]) begin
              btn_reg   <= {rx_byte[BTN_M], rx_byte[BTN_R], rx_byte[BTN_L]};
              xs_reg    <= rx_byte[XS];
              ys_reg    <= rx_byte[YS];
              xo_reg    <= rx_byte[XO];
              yo_reg    <= rx_byte[YO];
              state_reg <= ST_BX;
            end else begin
              o_err      <= 1'b1;
              o_err_code <= ERR_SYNC;
            end
          end
          ST_BX: begin
            x_reg     <= rx_byte;
            state_reg <= ST_BY;
          end
          ST_BY: begin
            y_reg     <= rx_byte;
            state_reg <= (P_WHEEL != 0) ? ST_BZ : ST_HDR;
          end
          default: state_reg <= ST_HDR;
        endcase
        if (last_byte) begin
          o_valid <= 1'b1;
          o_dx    <= dx_next;
          o_dy    <= dy_next;
          o_wheel <= (P_WHEEL != 0) ? rx_byte[3:0] : 4'd0;
          o_btn   <= btn_reg;
          o_x     <= x_next;
          o_y     <= y_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Self-checking bench for ps2_mouse_rx: one standard and one wheel instance
// driven with directed and random PS/2 traffic, checked against an
// arithmetic reference model of packet decoding and cursor clamping.
module tb_ps2_mouse_rx;

  localparam int HALF  = 8;     // system cycles per PS/2 half period
  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2c0 = 1'b1, ps2d0 = 1'b1, ps2c1 = 1'b1, ps2d1 = 1'b1;

  logic [8:0]  dx0, dy0, dx1, dy1;
  logic [3:0]  wheel0, wheel1;
  logic [2:0]  btn0, btn1;
  logic [11:0] x0, y0, x1, y1;
  logic        valid0, err0, valid1, err1;
  logic [1:0]  code0, code1;

  always #5 clk = ~clk;

  ps2_mouse_rx #(.P_CLK_HZ(1_000_000), .P_TIMEOUT_US(2000), .P_WHEEL(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_PS2Clk(ps2c0), .i_PS2Data(ps2d0),
    .o_dx(dx0), .o_dy(dy0), .o_wheel(wheel0), .o_btn(btn0), .o_x(x0), .o_y(y0),
    .o_valid(valid0), .o_err(err0), .o_err_code(code0));

  ps2_mouse_rx #(.P_CLK_HZ(1_000_000), .P_TIMEOUT_US(2000), .P_WHEEL(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_PS2Clk(ps2c1), .i_PS2Data(ps2d1),
    .o_dx(dx1), .o_dy(dy1), .o_wheel(wheel1), .o_btn(btn1), .o_x(x1), .o_y(y1),
    .o_valid(valid1), .o_err(err1), .o_err_code(code1));

  typedef struct {
    bit is_err;
    int code, dx, dy, wheel, btn, x, y, cyc;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  cyc = 0;
  int  last_fall = 0;
  int  n_cmp = 0, n_bad = 0;
  bit  both_hi = 1'b0;
  int  mx[2], my[2];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse with a snapshot of the outputs
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (valid0 && err0) both_hi = 1'b1;
      if (valid1 && err1) both_hi = 1'b1;
      if (valid0 || err0) begin
        e.is_err = err0; e.code = int'(code0); e.dx = int'($signed(dx0)); e.dy = int'($signed(dy0));
        e.wheel = int'($signed(wheel0)); e.btn = int'(btn0); e.x = int'(x0); e.y = int'(y0); e.cyc = cyc;
        q0.push_back(e);
      end
      if (valid1 || err1) begin
        e.is_err = err1; e.code = int'(code1); e.dx = int'($signed(dx1)); e.dy = int'($signed(dy1));
        e.wheel = int'($signed(wheel1)); e.btn = int'(btn1); e.x = int'(x1); e.y = int'(y1); e.cyc = cyc;
        q1.push_back(e);
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model helpers
  function automatic int delta(input bit s, input bit o, input int b);
    if (o) return s ? -256 : 255;
    return s ? b - 256 : b;
  endfunction

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic set_line(input int sel, input bit is_clk, input logic v);
    if (sel == 0) begin
      if (is_clk) ps2c0 = v; else ps2d0 = v;
    end else begin
      if (is_clk) ps2c1 = v; else ps2d1 = v;
    end
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      set_line(sel, 1'b0, fr[i]);
      repeat (HALF) @(negedge clk);
      set_line(sel, 1'b1, 1'b0);
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      set_line(sel, 1'b1, 1'b1);
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic pop_ev(input int sel, output ev_t e, output bit ok);
    ok = (sel == 0) ? (q0.size() > 0) : (q1.size() > 0);
    chk($sformatf("event_present_dut%0d", sel), int'(ok), 1);
    if (ok) e = (sel == 0) ? q0.pop_front() : q1.pop_front();
  endtask

  task automatic expect_err(input int sel, input int code);
    ev_t e; bit ok;
    pop_ev(sel, e, ok);
    if (!ok) return;
    chk("err_pulse", int'(e.is_err), 1);
    chk("err_code", e.code, code);
    $display("dut%0d err event code=%0d (expected %0d)", sel, e.code, code);
  endtask

  task automatic expect_none(input int sel);
    chk($sformatf("no_extra_events_dut%0d", sel), (sel == 0) ? q0.size() : q1.size(), 0);
    if (sel == 0) q0.delete(); else q1.delete();
  endtask

  // Send a complete packet and compare the outcome with the model
  task automatic send_pkt(input int sel, input logic [7:0] h, input logic [7:0] bx,
                          input logic [7:0] by, input logic [7:0] bz = 8'h00);
    int edx, edy, ew;
    ev_t e; bit ok;
    send_byte(sel, h);
    send_byte(sel, bx);
    send_byte(sel, by);
    if (sel == 1) send_byte(sel, bz);
    edx = delta(h[4], h[6], int'(bx));
    edy = delta(h[5], h[7], int'(by));
    ew  = 0;
    if (sel == 1) ew = (int'(bz[3:0]) > 7) ? int'(bz[3:0]) - 16 : int'(bz[3:0]);
    mx[sel] = clampi(mx[sel] + edx, X_MAX);
    my[sel] = clampi(my[sel] - edy, Y_MAX);
    pop_ev(sel, e, ok);
    if (!ok) return;
    chk("valid_pulse", int'(e.is_err), 0);
    chk("dx", e.dx, edx);
    chk("dy", e.dy, edy);
    chk("wheel", e.wheel, ew);
    chk("btn", e.btn, int'(h[2:0]));
    chk("x", e.x, mx[sel]);
    chk("y", e.y, my[sel]);
    chk("valid_latency", e.cyc - last_fall, 3);
    $display("dut%0d pkt %02h %02h %02h %02h -> dx=%0d dy=%0d w=%0d btn=%0d x=%0d y=%0d (exp %0d %0d %0d %0d %0d %0d)",
             sel, h, bx, by, bz, e.dx, e.dy, e.wheel, e.btn, e.x, e.y, edx, edy, ew, int'(h[2:0]), mx[sel], my[sel]);
    expect_none(sel);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mx[i] = X_MAX / 2;
      my[i] = Y_MAX / 2;
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    logic [7:0] h, a, b, c;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_dx", int'(dx0), 0);
    chk("rst_dy", int'(dy0), 0);
    chk("rst_wheel", int'(wheel1), 0);
    chk("rst_btn", int'(btn0), 0);
    chk("rst_x", int'(x0), 319);
    chk("rst_y", int'(y0), 239);
    chk("rst_x_wheel", int'(x1), 319);
    chk("rst_valid", int'(valid0 | valid1), 0);
    chk("rst_err", int'(err0 | err1), 0);
    chk("rst_code", int'(code0), 0);
    $display("reset values checked");

    // Basic packet: +5 right, 3 down
    send_pkt(0, 8'h28, 8'h05, 8'hFD);

    // Parity error in the middle of a packet, then recovery
    send_byte(0, 8'h09);
    send_byte(0, 8'h11, 1'b1);
    expect_err(0, 1);
    expect_none(0);
    send_pkt(0, 8'h09, 8'h01, 8'h00);

    // Bad stop bit
    send_byte(0, 8'h08);
    send_byte(0, 8'h22, 1'b0, 1'b1);
    expect_err(0, 0);
    expect_none(0);
    send_pkt(0, 8'h0A, 8'h03, 8'h04);

    // Stream starting mid-packet: header without bit3 is rejected
    send_byte(0, 8'h05);
    expect_err(0, 2);
    expect_none(0);
    send_pkt(0, 8'h08, 8'h02, 8'h02);

    // Positive X overflow from centre saturates and the cursor clamps
    do_reset();
    for (int i = 0; i < 3; i++) send_pkt(0, 8'h48, 8'h10, 8'h00);
    // Negative overflows on both axes
    send_pkt(0, 8'hF8, 8'h00, 8'h00);
    send_pkt(0, 8'h5C, 8'h80, 8'h00);

    // Inter-byte timeout, then a full packet is accepted
    send_byte(0, 8'h08);
    send_byte(0, 8'h10);
    repeat (2500) @(negedge clk);
    expect_err(0, 3);
    expect_none(0);
    send_pkt(0, 8'h0C, 8'h07, 8'hF0);

    // Random packets
    for (int i = 0; i < 16; i++) begin
      h = 8'($urandom) | 8'h08;
      a = 8'($urandom);
      b = 8'($urandom);
      send_pkt(0, h, a, b);
    end

    // Wheel packets
    send_pkt(1, 8'h08, 8'h00, 8'h00, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      h = 8'($urandom) | 8'h08;
      a = 8'($urandom);
      b = 8'($urandom);
      c = 8'($urandom);
      send_pkt(1, h, a, b, c);
    end

    // Wheel mode: a 3-byte packet never completes and times out
    send_byte(1, 8'h08);
    send_byte(1, 8'h01);
    send_byte(1, 8'h01);
    repeat (2500) @(negedge clk);
    expect_err(1, 3);
    expect_none(1);
    send_pkt(1, 8'h19, 8'h04, 8'hFC, 8'h01);

    chk("valid_err_exclusive", int'(both_hi), 0);
    expect_none(0);
    expect_none(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
